// File: rtl/lcd_value_writer_if.sv
// Character-write channel between lcd_value_writer (master) and the LCD driver (slave).
// A character moves on a rising clk edge where lcd_valid && lcd_ready; lcd_addr/lcd_data are held until then.
interface lcd_value_writer_if;
  logic       lcd_valid;
  logic       lcd_ready;
  logic [6:0] lcd_addr;
  logic [7:0] lcd_data;

  modport master (output lcd_valid, output lcd_addr, output lcd_data, input lcd_ready);
  modport slave  (input lcd_valid, input lcd_addr, input lcd_data, output lcd_ready);
endinterface

// File: rtl/lcd_value_writer.sv
// Converts a 12-bit value to three ASCII digits by repeated subtraction and streams them to the LCD.
// Optional macro LEADING_BLANK_EN replaces leading zeros of the hundreds/tens digits with spaces.
module lcd_value_writer #(
  parameter logic [6:0] BASE_ADDR = 7'h40,
  parameter logic [7:0] OVF_CHAR  = 8'h2D
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [11:0]        val,
  output logic               busy,
  output logic               done,
  output logic [2:0]         dbg_state,
  lcd_value_writer_if.master lcd
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CONV_H = 3'd1,
    S_CONV_T = 3'd2,
    S_SEND_H = 3'd3,
    S_SEND_T = 3'd4,
    S_SEND_O = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t      state, state_nxt;
  logic [11:0] rem;
  logic [3:0]  h, t, ones;
  logic        ovf;
  logic [6:0]  addr_q;
  logic [7:0]  data_q;
  logic        valid;
  logic        xfer;
  logic [7:0]  hund_chr, tens_chr, ones_chr;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  // Character selection; h and t are final by the time each is loaded.
  always_comb begin
    ones_chr = digit_char(ones);
`ifdef LEADING_BLANK_EN
    hund_chr = (h == 4'd0) ? 8'h20 : digit_char(h);
    tens_chr = (h == 4'd0 && t == 4'd0) ? 8'h20 : digit_char(t);
`else
    hund_chr = digit_char(h);
    tens_chr = digit_char(t);
`endif
  end

  assign xfer      = valid && lcd.lcd_ready;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    valid     = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (val > 12'd999) ? S_SEND_H : S_CONV_H;
      end
      S_CONV_H: if (rem < 12'd100) state_nxt = S_CONV_T;
      S_CONV_T: if (rem < 12'd10)  state_nxt = S_SEND_H;
      S_SEND_H: begin
        valid = 1'b1;
        if (lcd.lcd_ready) state_nxt = S_SEND_T;
      end
      S_SEND_T: begin
        valid = 1'b1;
        if (lcd.lcd_ready) state_nxt = S_SEND_O;
      end
      S_SEND_O: begin
        valid = 1'b1;
        if (lcd.lcd_ready) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address/data are loaded on the edge entering each SEND state so they are stable for its whole duration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem    <= 12'd0;
      h      <= 4'd0;
      t      <= 4'd0;
      ones   <= 4'd0;
      ovf    <= 1'b0;
      addr_q <= 7'd0;
      data_q <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rem  <= val;
            h    <= 4'd0;
            t    <= 4'd0;
            ones <= 4'd0;
            ovf  <= (val > 12'd999);
            if (val > 12'd999) begin
              addr_q <= BASE_ADDR;
              data_q <= OVF_CHAR;
            end
          end
        end
        S_CONV_H: begin
          if (rem >= 12'd100) begin
            rem <= rem - 12'd100;
            h   <= h + 4'd1;
          end
        end
        S_CONV_T: begin
          if (rem >= 12'd10) begin
            rem <= rem - 12'd10;
            t   <= t + 4'd1;
          end else begin
            ones   <= rem[3:0];
            addr_q <= BASE_ADDR;
            data_q <= hund_chr;
          end
        end
        S_SEND_H: begin
          if (xfer) begin
            addr_q <= BASE_ADDR + 7'd1;
            data_q <= ovf ? OVF_CHAR : tens_chr;
          end
        end
        S_SEND_T: begin
          if (xfer) begin
            addr_q <= BASE_ADDR + 7'd2;
            data_q <= ovf ? OVF_CHAR : ones_chr;
          end
        end
        default: ;
      endcase
    end
  end

  assign lcd.lcd_valid = valid;
  assign lcd.lcd_addr  = addr_q;
  assign lcd.lcd_data  = data_q;

endmodule

// File: tb/tb_lcd_value_writer.sv
// Directed bench for lcd_value_writer: decimal model via div/mod feeds an expected transfer queue,
// a negedge monitor checks every transfer, stall stability and done pulses.
module tb_lcd_value_writer;

  localparam logic [6:0] BASE = 7'h40;
`ifdef LEADING_BLANK_EN
  localparam logic [7:0] LZ = 8'h20;
`else
  localparam logic [7:0] LZ = 8'h30;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] val;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  lcd_value_writer_if lcd_bus ();

  lcd_value_writer #(.BASE_ADDR(BASE), .OVF_CHAR(8'h2D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .val       (val),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state),
    .lcd       (lcd_bus)
  );

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int c0       = 0;
  int d0       = 0;
  int done_cnt = 0;
  int rst_cnt  = 0;
  int seen_rst = 0;

  logic [14:0] exp_q[$];
  logic [14:0] got_q[$];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Model: decimal digits by arithmetic, overflow and leading-blank rules applied directly.
  task automatic model_push(input logic [11:0] v);
    logic [7:0] c [3];
    int hd, td, od;
    if (v > 12'd999) begin
      for (int i = 0; i < 3; i++) c[i] = 8'h2D;
    end else begin
      hd = int'(v) / 100;
      td = (int'(v) / 10) % 10;
      od = int'(v) % 10;
      c[0] = 8'(8'h30 + hd);
      c[1] = 8'(8'h30 + td);
      c[2] = 8'(8'h30 + od);
`ifdef LEADING_BLANK_EN
      if (hd == 0) c[0] = 8'h20;
      if (hd == 0 && td == 0) c[1] = 8'h20;
`endif
    end
    for (int i = 0; i < 3; i++) exp_q.push_back({7'(BASE + 7'(i)), c[i]});
  endtask

  // monitor / scoreboard
  logic        prev_stall = 1'b0;
  logic        prev_done  = 1'b0;
  logic [6:0]  prev_addr  = 7'd0;
  logic [7:0]  prev_data  = 8'd0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rst_cnt != seen_rst) begin
        seen_rst   = rst_cnt;
        prev_stall = 1'b0;
        prev_done  = 1'b0;
      end
      if (prev_stall) begin
        check("stall_valid", 32'(lcd_bus.lcd_valid), 32'd1);
        check("stall_addr", 32'(lcd_bus.lcd_addr), 32'(prev_addr));
        check("stall_data", 32'(lcd_bus.lcd_data), 32'(prev_data));
      end
      if (lcd_bus.lcd_valid && lcd_bus.lcd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_xfer got=%0h exp=none", {lcd_bus.lcd_addr, lcd_bus.lcd_data});
        end else begin
          check("xfer", 32'({lcd_bus.lcd_addr, lcd_bus.lcd_data}), 32'(exp_q.pop_front()));
        end
        got_q.push_back({lcd_bus.lcd_addr, lcd_bus.lcd_data});
      end
      if (lcd_bus.lcd_valid) check("valid_implies_busy", 32'(busy), 32'd1);
      if (done) begin
        done_cnt++;
        check("done_one_cycle", 32'(prev_done), 32'd0);
        check("done_no_valid", 32'(lcd_bus.lcd_valid), 32'd0);
      end
      prev_stall = lcd_bus.lcd_valid && !lcd_bus.lcd_ready;
      prev_addr  = lcd_bus.lcd_addr;
      prev_data  = lcd_bus.lcd_data;
      prev_done  = done;
    end
  end

  // driver tasks; all are entered and left 1 time unit after a rising edge
  task automatic begin_op(input logic [11:0] v, input bit hold);
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_before_start", 32'(busy), 32'd0);
    model_push(v);
    got_q.delete();
    d0    = done_cnt;
    start = 1'b1;
    val   = v;
    @(posedge clk);
    c0 = cycle;
    #1;
    start = hold;
    check("busy_rise", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input bit stall, input bit pulse, input bit hold,
                           input int exp_lat, input string name);
    bit seen = 1'b0;
    int stall_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (stall && lcd_bus.lcd_valid && stall_cnt < 5) begin
        lcd_bus.lcd_ready = 1'b0;
        stall_cnt++;
      end else begin
        lcd_bus.lcd_ready = 1'b1;
        if (lcd_bus.lcd_valid) stall_cnt = 0;
      end
      if (pulse) start = (k % 3 == 1);
      @(posedge clk); #1;
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) check({name, "_latency"}, 32'(cycle - c0), 32'(exp_lat));
    if (!hold) start = 1'b0;
    lcd_bus.lcd_ready = 1'b1;
    @(posedge clk); #1;
    check({name, "_busy_fall"}, 32'(busy), 32'd0);
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({name, "_done_count"}, 32'(done_cnt), 32'(d0 + 1));
  endtask

  task automatic check_got(input string name, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2);
    logic [7:0] e [3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    check({name, "_xfer_count"}, 32'(got_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (got_q.size() > i) begin
        check({name, "_addr"}, 32'(got_q[i][14:8]), 32'(BASE + 7'(i)));
        check({name, "_char"}, 32'(got_q[i][7:0]), 32'(e[i]));
      end
    end
  endtask

  initial begin
    bit found;
    rst_n = 1'b0;
    start = 1'b0;
    val   = 12'd0;
    lcd_bus.lcd_ready = 1'b1;
    #23;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(lcd_bus.lcd_valid), 32'd0);
    check("rst_addr", 32'(lcd_bus.lcd_addr), 32'd0);
    check("rst_data", 32'(lcd_bus.lcd_data), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: zero value
    begin_op(12'd0, 1'b0);
    wait_done(1'b0, 1'b0, 1'b0, 6, "t1");
    check_got("t1", LZ, LZ, 8'h30);

    // 2: largest decimal value, start pulses while busy must be ignored
    begin_op(12'd999, 1'b0);
    wait_done(1'b0, 1'b1, 1'b0, 24, "t2");
    check_got("t2", 8'h39, 8'h39, 8'h39);
    repeat (4) begin @(posedge clk); #1; end
    check("t2_no_extra_op", 32'(busy), 32'd0);

    // 3: overflow skips conversion
    begin_op(12'd4095, 1'b0);
    wait_done(1'b0, 1'b0, 1'b0, 4, "t3");
    check_got("t3", 8'h2D, 8'h2D, 8'h2D);

    // 4: five stall cycles in every SEND state
    begin_op(12'd507, 1'b0);
    wait_done(1'b1, 1'b0, 1'b0, 26, "t4");
    check_got("t4", 8'h35, 8'h30, 8'h37);

    // 5: reset while the tens character is pending, then a fresh operation
    begin_op(12'd123, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (lcd_bus.lcd_valid && lcd_bus.lcd_addr == BASE + 7'd1) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("t5_reach_send_t", 32'(found), 32'd1);
    lcd_bus.lcd_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    rst_cnt++;
    #1;
    check("t5_rst_valid", 32'(lcd_bus.lcd_valid), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_addr", 32'(lcd_bus.lcd_addr), 32'd0);
    exp_q.delete();
    #1;
    rst_n = 1'b1;
    lcd_bus.lcd_ready = 1'b1;
    begin_op(12'd42, 1'b0);
    wait_done(1'b0, 1'b0, 1'b0, 10, "t5");
    check_got("t5", LZ, 8'h34, 8'h32);

    // 6: start held high gives back-to-back operations with one idle cycle between
    begin_op(12'd100, 1'b1);
    wait_done(1'b0, 1'b0, 1'b1, 7, "t6a");
    check_got("t6a", 8'h31, 8'h30, 8'h30);
    model_push(12'd100);
    got_q.delete();
    d0 = done_cnt;
    @(posedge clk);
    c0 = cycle;
    #1;
    check("t6_busy_again", 32'(busy), 32'd1);
    wait_done(1'b0, 1'b0, 1'b0, 7, "t6b");
    check_got("t6b", 8'h31, 8'h30, 8'h30);

    repeat (4) begin @(posedge clk); #1; end
    check("final_idle", 32'(busy), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
